// File: rtl/vector_regfile.sv
// -----------------------------------------------------------------------------
// vector_regfile
//   Flop-based vector register file answering the vector ALU's vreg read and
//   write ports, with a sequenced bulk-clear engine used between kernels.
//
//   Reads: request in cycle N, vreg_rd_ready strobe and registered data in
//   cycle N+1. A read request costs two cycles (IDLE -> RESP -> IDLE).
//   Writes: commit in one cycle whenever the clear engine is idle.
//   Clear: zeroes one register per cycle for NUM_VREGS cycles, then pulses
//   clear_done. Reads and writes are held off while clearing.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   vreg_rd_valid/idx read request and 5-bit register index
//   vreg_rd_data      registered read data, lane 0 in the low DATA_WIDTH bits
//   vreg_rd_ready     one-cycle read-completion strobe
//   vreg_wr_valid/idx write request and 5-bit register index
//   vreg_wr_data      write data, all lanes, lane 0 in the low bits
//   vreg_wr_ready     write accepted when high with vreg_wr_valid
//   clear_start       pulse: begin bulk clear
//   clear_busy        high while clearing
//   clear_done        one-cycle pulse after the last register is cleared
// -----------------------------------------------------------------------------
module vector_regfile #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VREGS  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vreg_rd_valid,
  input  logic [4:0]                    vreg_rd_idx,
  output logic [LANES*DATA_WIDTH-1:0]   vreg_rd_data,
  output logic                          vreg_rd_ready,
  input  logic                          vreg_wr_valid,
  input  logic [4:0]                    vreg_wr_idx,
  input  logic [LANES*DATA_WIDTH-1:0]   vreg_wr_data,
  output logic                          vreg_wr_ready,
  input  logic                          clear_start,
  output logic                          clear_busy,
  output logic                          clear_done
);

  localparam int         VW       = LANES * DATA_WIDTH;
  localparam logic [4:0] LAST_IDX = 5'(NUM_VREGS - 1);

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  rd_state_e         rd_state_q, rd_state_d;
  logic              rd_accept_s;
  logic [VW-1:0]     rd_word_s;
  logic [VW-1:0]     rd_data_q, rd_data_d;
  logic              rd_ready_q, rd_ready_d;

  logic              clr_busy_q, clr_busy_d;
  logic              clr_done_q, clr_done_d;
  logic [4:0]        clr_cnt_q, clr_cnt_d;

  logic              wr_en_s;
  logic [VW-1:0]     mem_q [NUM_VREGS];

  // Read mux: indices with no implemented register fall through to zero.
  always_comb begin
    rd_word_s = '0;
    for (int i = 0; i < NUM_VREGS; i++) begin
      rd_word_s = (vreg_rd_idx == 5'(i)) ? mem_q[i] : rd_word_s;
    end
  end

  // Read FSM next state; new requests are held off while the clear runs.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_accept_s = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (vreg_rd_valid && !clr_busy_q) begin
          rd_accept_s = 1'b1;
          rd_state_d  = RD_RESP;
        end else begin
          rd_state_d  = RD_IDLE;
        end
      end
      RD_RESP: rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
    rd_ready_d = rd_accept_s;
    // Data is captured at the accepting edge, so a same-cycle write is not seen.
    rd_data_d  = rd_accept_s ? rd_word_s : rd_data_q;
  end

  // Read FSM state and registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_data_q  <= '0;
      rd_ready_q <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_data_q  <= rd_data_d;
      rd_ready_q <= rd_ready_d;
    end
  end

  // Clear engine next state: walk the counter from 0 to LAST_IDX, then done.
  always_comb begin
    clr_busy_d = clr_busy_q;
    clr_cnt_d  = clr_cnt_q;
    clr_done_d = 1'b0;
    if (clr_busy_q) begin
      if (clr_cnt_q == LAST_IDX) begin
        clr_busy_d = 1'b0;
        clr_done_d = 1'b1;
      end else begin
        clr_cnt_d  = clr_cnt_q + 5'd1;
      end
    end else if (clear_start) begin
      clr_busy_d = 1'b1;
      clr_cnt_d  = 5'd0;
    end else begin
      clr_busy_d = 1'b0;
    end
  end

  // Clear engine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      clr_cnt_q  <= 5'd0;
    end else begin
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      clr_cnt_q  <= clr_cnt_d;
    end
  end

  // Writes and clear never overlap: writes are only enabled while not busy.
  assign wr_en_s = vreg_wr_valid && !clr_busy_q;

  // Register array: out-of-range write indices match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VREGS; i++) begin
        if (wr_en_s && (vreg_wr_idx == 5'(i))) begin
          mem_q[i] <= vreg_wr_data;
        end else if (clr_busy_q && (clr_cnt_q == 5'(i))) begin
          mem_q[i] <= '0;
        end else begin
          mem_q[i] <= mem_q[i];
        end
      end
    end
  end

  assign vreg_rd_data  = rd_data_q;
  assign vreg_rd_ready = rd_ready_q;
  assign vreg_wr_ready = !clr_busy_q;
  assign clear_busy    = clr_busy_q;
  assign clear_done    = clr_done_q;

endmodule

// File: doc/vector_regfile.md
Name: vector_regfile

Overview:
- Vector register file that serves as the responder for the vector ALU's vreg read and write ports.
- Holds NUM_VREGS registers, each LANES x DATA_WIDTH, in flops.
- Reads complete one cycle after a request, with a registered read-data output. Writes commit in a single cycle.
- A sequenced bulk-clear engine zeroes the file one register per cycle. It is used by the scheduler between kernels.

Parameters:
- LANES, 4, lanes per vector register.
- DATA_WIDTH, 32, bits per lane.
- NUM_VREGS, 32, number of implemented registers, 1..32. Index ports are always 5 bits wide.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- vreg_rd_valid  input  1  read request from ALU.
- vreg_rd_idx  input  5  register to read.
- vreg_rd_data  output  LANES x DATA_WIDTH  registered read data, one entry per lane.
- vreg_rd_ready  output  1  one-cycle read-completion strobe; vreg_rd_data is valid in this cycle.
- vreg_wr_valid  input  1  write request.
- vreg_wr_idx  input  5  register to write.
- vreg_wr_data  input  LANES x DATA_WIDTH  write data, all lanes.
- vreg_wr_ready  output  1  write accepted when high with vreg_wr_valid.
- clear_start  input  1  pulse: begin bulk clear.
- clear_busy  output  1  high while clearing.
- clear_done  output  1  one-cycle pulse after the last register is cleared.

Behaviour:
- Reset (asynchronous, rst_n low):
  - all registers, all lanes = 0; vreg_rd_data = 0.
  - vreg_rd_ready = 0, clear_busy = 0, clear_done = 0.
  - read FSM = IDLE, clear counter = 0.
  - vreg_wr_ready = 1 after reset release.
- Read FSM, states IDLE and RESP:
  - IDLE: if vreg_rd_valid=1 and clear_busy=0, latch vreg_rd_idx, go to RESP.
  - RESP: vreg_rd_ready=1; vreg_rd_data = registered array contents of the latched index, sampled at the IDLE->RESP clock edge; return to IDLE.
  - Latency: request in cycle N, data and strobe in cycle N+1.
  - Sustained vreg_rd_valid gives one completion every 2 cycles. vreg_rd_valid is ignored during RESP.
  - vreg_rd_data holds its last value between reads.
- Write:
  - vreg_wr_ready = !clear_busy (combinational).
  - Commit at the edge where vreg_wr_valid && vreg_wr_ready; all lanes are written.
- Read/write ordering:
  - Same-cycle write and read request to the same index: the read returns the OLD value (no forwarding).
  - A write committed in cycle N is visible to a read requested in cycle N+1.
- Out of range (idx >= NUM_VREGS):
  - Write is accepted and dropped.
  - Read completes normally and returns all zeros.
- Clear FSM:
  - clear_start while clear_busy=0: clear_busy=1 next cycle, counter=0.
  - Each busy cycle zeroes register[counter], then counter increments.
  - After register NUM_VREGS-1 is cleared: clear_busy=0 and clear_done=1 for exactly one cycle.
  - Total: clear_busy is high for NUM_VREGS cycles.
  - clear_start while busy is ignored; no restart.
- Clear vs. read:
  - A read already in RESP completes with pre-clear data.
  - New reads are not accepted while busy and are held off until clear_busy=0.
- Clear vs. write: with clear_start and a write in the same cycle, the write commits (wr_ready is still 1) and is then zeroed by the clear.
- Reset mid-clear or mid-read: everything returns to the reset state immediately; no clear_done or rd_ready pulse is produced.

Test Plan:
- Write vreg 3 with lanes {1,2,3,4}, then read vreg 3 → vreg_rd_ready is high exactly 1 cycle after the request, and vreg_rd_data = {1,2,3,4}.
- Same-cycle write vreg 5 = all 0xAAAA_AAAA while reading vreg 5 (prior value 0) → read returns 0. A read on the next request returns 0xAAAA_AAAA.
- Hold vreg_rd_valid high for 6 cycles → exactly 3 vreg_rd_ready pulses, in alternate cycles.
- Fill all 32 regs with nonzero data, pulse clear_start:
  - clear_busy is high for 32 cycles and vreg_wr_ready is low throughout.
  - clear_done pulses once.
  - All reads afterwards return 0.
  - A second clear_start mid-clear has no effect on the timing.
- NUM_VREGS=8: write idx 12 = 0xDEAD_BEEF, then read idx 12 → returns 0, and regs 0-7 are unchanged.
- Assert rst_n low at clear cycle 10 → clear_busy=0 immediately, all regs read 0 after release, no clear_done pulse.
